// File: rtl/pc_redirect_ctrl.sv
// Fetch PC redirect controller: queues predicted-taken fallthroughs, redirects on mispredict/jump.
// Optional statistics outputs are compiled in when PC_REDIRECT_STATS_EN is defined.
module pc_redirect_ctrl #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pred_valid,
   input  logic [DATA_WIDTH-1:0] pred_pc,
   input  logic [DATA_WIDTH-1:0] pred_target,
   input  logic                  resolve_valid,
   input  logic                  resolve_taken,
   input  logic                  jump_valid,
   input  logic [DATA_WIDTH-1:0] jump_target,
   output logic                  redirect_valid,
   output logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  flush,
   output logic                  stall_fetch,
   output logic                  err_underflow
`ifdef PC_REDIRECT_STATS_EN
   ,
   output logic [31:0]           pred_count,
   output logic [31:0]           mispred_count
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic {
      S_IDLE,
      S_RECOVER
   } state_e;

   state_e                state_q, state_d;
   logic [FC_W-1:0]       fcnt_q, fcnt_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  redirect_valid_q, redirect_valid_d;
   logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic full, empty, push, pop, mispred;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d          = state_q;
      fcnt_d           = fcnt_q;
      rd_ptr_d         = rd_ptr_q;
      wr_ptr_d         = wr_ptr_q;
      count_d          = count_q;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      err_d            = err_q;
      push             = 1'b0;
      pop              = 1'b0;
      mispred          = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (resolve_valid && empty) begin
               err_d = 1'b1;
            end
            if (jump_valid) begin
               redirect_valid_d = 1'b1;
               redirect_pc_d    = jump_target;
            end else if (resolve_valid && !resolve_taken && !empty) begin
               mispred          = 1'b1;
               redirect_valid_d = 1'b1;
               redirect_pc_d    = mem[rd_ptr_q];
            end else begin
               pop  = resolve_valid && resolve_taken && !empty;
               push = pred_valid && !full;
               if (pop) begin
                  rd_ptr_d = rd_ptr_q + PTR_W'(1);
               end
               if (push) begin
                  wr_ptr_d         = wr_ptr_q + PTR_W'(1);
                  redirect_valid_d = 1'b1;
                  redirect_pc_d    = pred_target;
               end
               if (push && !pop) begin
                  count_d = count_q + CNT_W'(1);
               end else if (!push && pop) begin
                  count_d = count_q - CNT_W'(1);
               end
            end
            if (jump_valid || mispred) begin
               state_d  = S_RECOVER;
               fcnt_d   = FC_W'(FLUSH_CYCLES);
               rd_ptr_d = '0;
               wr_ptr_d = '0;
               count_d  = '0;
            end
         end
         S_RECOVER: begin
            // Only a jump can interrupt recovery; it restarts the flush window.
            if (jump_valid) begin
               redirect_valid_d = 1'b1;
               redirect_pc_d    = jump_target;
               fcnt_d           = FC_W'(FLUSH_CYCLES);
            end else if (fcnt_q == FC_W'(1)) begin
               state_d = S_IDLE;
            end else begin
               fcnt_d = fcnt_q - FC_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= S_IDLE;
         fcnt_q           <= '0;
         rd_ptr_q         <= '0;
         wr_ptr_q         <= '0;
         count_q          <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         err_q            <= 1'b0;
      end else begin
         state_q          <= state_d;
         fcnt_q           <= fcnt_d;
         rd_ptr_q         <= rd_ptr_d;
         wr_ptr_q         <= wr_ptr_d;
         count_q          <= count_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         err_q            <= err_d;
      end
   end

   // NOTE: queue storage is not reset; count and pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= pred_pc + DATA_WIDTH'(4);
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign flush          = (state_q == S_RECOVER);
   assign stall_fetch    = full;
   assign err_underflow  = err_q;

`ifdef PC_REDIRECT_STATS_EN
   logic [31:0] pred_cnt_q, pred_cnt_d;
   logic [31:0] mispred_cnt_q, mispred_cnt_d;

   always_comb begin
      pred_cnt_d    = pred_cnt_q + (push ? 32'd1 : 32'd0);
      mispred_cnt_d = mispred_cnt_q + (mispred ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_cnt_q    <= '0;
         mispred_cnt_q <= '0;
      end else begin
         pred_cnt_q    <= pred_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign pred_count    = pred_cnt_q;
   assign mispred_count = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_pc_redirect_ctrl;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int FC    = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pred_valid;
   logic [DW-1:0] pred_pc;
   logic [DW-1:0] pred_target;
   logic          resolve_valid;
   logic          resolve_taken;
   logic          jump_valid;
   logic [DW-1:0] jump_target;
   logic          redirect_valid;
   logic [DW-1:0] redirect_pc;
   logic          flush;
   logic          stall_fetch;
   logic          err_underflow;
`ifdef PC_REDIRECT_STATS_EN
   logic [31:0]   pred_count;
   logic [31:0]   mispred_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pc_redirect_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pred_valid     (pred_valid),
      .pred_pc        (pred_pc),
      .pred_target    (pred_target),
      .resolve_valid  (resolve_valid),
      .resolve_taken  (resolve_taken),
      .jump_valid     (jump_valid),
      .jump_target    (jump_target),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .stall_fetch    (stall_fetch),
      .err_underflow  (err_underflow)
`ifdef PC_REDIRECT_STATS_EN
      ,
      .pred_count     (pred_count),
      .mispred_count  (mispred_count)
`endif
   );

   // Reference model: pending fallthroughs as a queue, recovery as a cycles-left counter.
   logic [DW-1:0] m_q[$];
   bit            m_rec;
   int            m_left;
   bit            m_err;
   bit            m_rv;
   logic [DW-1:0] m_rpc;
   logic [31:0]   m_pred_n;
   logic [31:0]   m_mis_n;

   function automatic void model_reset();
      m_q.delete();
      m_rec    = 1'b0;
      m_left   = 0;
      m_err    = 1'b0;
      m_rv     = 1'b0;
      m_rpc    = '0;
      m_pred_n = '0;
      m_mis_n  = '0;
   endfunction

   function automatic void model_step();
      bit was_full;
      m_rv = 1'b0;
      if (m_rec) begin
         if (jump_valid) begin
            m_rv   = 1'b1;
            m_rpc  = jump_target;
            m_left = FC;
         end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_rec = 1'b0;
         end
      end else begin
         if (resolve_valid && m_q.size() == 0) m_err = 1'b1;
         if (jump_valid) begin
            m_rv  = 1'b1;
            m_rpc = jump_target;
            m_q.delete();
            m_rec  = 1'b1;
            m_left = FC;
         end else if (resolve_valid && !resolve_taken && m_q.size() > 0) begin
            m_rv  = 1'b1;
            m_rpc = m_q[0];
            m_q.delete();
            m_rec   = 1'b1;
            m_left  = FC;
            m_mis_n = m_mis_n + 1;
         end else begin
            was_full = (m_q.size() == DEPTH);
            if (resolve_valid && resolve_taken && m_q.size() > 0) void'(m_q.pop_front());
            if (pred_valid && !was_full) begin
               m_q.push_back(pred_pc + 32'd4);
               m_rv     = 1'b1;
               m_rpc    = pred_target;
               m_pred_n = m_pred_n + 1;
            end
         end
      end
   endfunction

   task automatic drive(input bit pv, input logic [DW-1:0] ppc, input logic [DW-1:0] ptgt,
                        input bit rv, input bit rt, input bit jv, input logic [DW-1:0] jt);
      pred_valid    = pv;
      pred_pc       = ppc;
      pred_target   = ptgt;
      resolve_valid = rv;
      resolve_taken = rt;
      jump_valid    = jv;
      jump_target   = jt;
   endtask

   task automatic idle();
      drive(0, '0, '0, 0, 0, 0, '0);
   endtask

   // Advance one clock: model and DUT consume the same inputs, then outputs settle.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got=%b exp=0", redirect_valid); end
      n_checks++; if (redirect_pc !== '0) begin n_fail++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=0", flush); end
      n_checks++; if (stall_fetch !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall_fetch); end
      n_checks++; if (err_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
      rst_n = 1'b1;
   endtask

   task automatic test_predict();
      drive(1, 32'h100, 32'h140, 0, 0, 0, '0);
      tick();
      idle();
      n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL pred_rv got=%b exp=1", redirect_valid); end
      n_checks++; if (redirect_pc !== 32'h140) begin n_fail++; $display("FAIL pred_rpc got=%h exp=140", redirect_pc); end
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL pred_flush got=%b exp=0", flush); end
      tick();
      n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL pred_rv_pulse got=%b exp=0", redirect_valid); end
   endtask

   task automatic test_mispredict();
      drive(0, '0, '0, 1, 0, 0, '0);
      tick();
      idle();
      n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL mis_rv got=%b exp=1", redirect_valid); end
      n_checks++; if (redirect_pc !== 32'h104) begin n_fail++; $display("FAIL mis_rpc got=%h exp=104", redirect_pc); end
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL mis_flush0 got=%b exp=1", flush); end
      tick();
      n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL mis_rv_pulse got=%b exp=0", redirect_valid); end
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL mis_flush1 got=%b exp=1", flush); end
      tick();
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL mis_flush2 got=%b exp=0", flush); end
   endtask

   task automatic test_full();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 32'h1000 + 32'(16 * i), 32'h2000 + 32'(16 * i), 0, 0, 0, '0);
         tick();
      end
      n_checks++; if (stall_fetch !== 1'b1) begin n_fail++; $display("FAIL full_stall got=%b exp=1", stall_fetch); end
      drive(1, 32'h1040, 32'h2040, 0, 0, 0, '0);
      tick();
      n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL full_drop_rv got=%b exp=0", redirect_valid); end
      drive(0, '0, '0, 1, 1, 0, '0);
      tick();
      n_checks++; if (stall_fetch !== 1'b0) begin n_fail++; $display("FAIL full_unstall got=%b exp=0", stall_fetch); end
      // Simultaneous push and correct pop, then a mispredict exposes the new head.
      drive(1, 32'h1050, 32'h2050, 1, 1, 0, '0);
      tick();
      n_checks++; if (redirect_pc !== 32'h2050 || redirect_valid !== 1'b1) begin n_fail++; $display("FAIL pushpop_rv got=%b/%h exp=1/2050", redirect_valid, redirect_pc); end
      n_checks++; if (stall_fetch !== 1'b0) begin n_fail++; $display("FAIL pushpop_stall got=%b exp=0", stall_fetch); end
      drive(0, '0, '0, 1, 0, 0, '0);
      tick();
      idle();
      n_checks++; if (redirect_pc !== 32'h1024) begin n_fail++; $display("FAIL fifo_order got=%h exp=1024", redirect_pc); end
      repeat (FC) tick();
   endtask

   task automatic test_priority();
      drive(1, 32'h300, 32'h340, 0, 0, 0, '0);
      tick();
      drive(1, 32'h400, 32'h500, 1, 0, 1, 32'h200);
      tick();
      idle();
      n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin n_fail++; $display("FAIL prio_rpc got=%b/%h exp=1/200", redirect_valid, redirect_pc); end
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL prio_flush got=%b exp=1", flush); end
      repeat (FC) tick();
   endtask

   task automatic test_underflow();
      drive(0, '0, '0, 1, 1, 0, '0);
      tick();
      idle();
      n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uflow_err got=%b exp=1", err_underflow); end
      n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL uflow_rv got=%b exp=0", redirect_valid); end
      tick();
      n_checks++; if (err_underflow !== 1'b1) begin n_fail++; $display("FAIL uflow_sticky got=%b exp=1", err_underflow); end
   endtask

   task automatic test_recover_jump();
      drive(0, '0, '0, 0, 0, 1, 32'h600);
      tick();
      drive(0, '0, '0, 0, 0, 1, 32'h700);
      tick();
      n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h700) begin n_fail++; $display("FAIL rejump_rpc got=%b/%h exp=1/700", redirect_valid, redirect_pc); end
      drive(1, 32'h800, 32'h880, 0, 0, 0, '0);
      tick();
      idle();
      n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rec_ignore_pred got=%b exp=0", redirect_valid); end
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL rejump_restart got=%b exp=1", flush); end
      tick();
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rejump_end got=%b exp=0", flush); end
   endtask

   task automatic test_reset_mid_recover();
      drive(0, '0, '0, 0, 0, 1, 32'h900);
      tick();
      idle();
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL arst_flush got=%b exp=0", flush); end
      n_checks++; if (redirect_valid !== 1'b0 || redirect_pc !== '0) begin n_fail++; $display("FAIL arst_rv got=%b/%h exp=0/0", redirect_valid, redirect_pc); end
      n_checks++; if (err_underflow !== 1'b0 || stall_fetch !== 1'b0) begin n_fail++; $display("FAIL arst_err_stall got=%b/%b exp=0/0", err_underflow, stall_fetch); end
      #2;
      rst_n = 1'b1;
      drive(1, 32'hA00, 32'hA40, 0, 0, 0, '0);
      tick();
      idle();
      n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'hA40 || flush !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got=%b/%h/%b exp=1/a40/0", redirect_valid, redirect_pc, flush); end
   endtask

   task automatic test_random();
      logic [DW-1:0] ppc;
      for (int c = 0; c < 400; c++) begin
         ppc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         drive($urandom_range(0, 9) < 6, ppc, $urandom() & 32'hFFFF_FFFC,
               $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
               $urandom_range(0, 19) == 0, $urandom() & 32'hFFFF_FFFC);
         tick();
         n_checks++;
         if (redirect_valid !== m_rv || (m_rv && redirect_pc !== m_rpc)) begin
            n_fail++; $display("FAIL rnd_redirect c=%0d got=%b/%h exp=%b/%h", c, redirect_valid, redirect_pc, m_rv, m_rpc);
         end
         n_checks++;
         if (flush !== m_rec || stall_fetch !== (m_q.size() == DEPTH) || err_underflow !== m_err) begin
            n_fail++; $display("FAIL rnd_status c=%0d got=%b%b%b exp=%b%b%b", c, flush, stall_fetch, err_underflow,
                               m_rec, (m_q.size() == DEPTH), m_err);
         end
`ifdef PC_REDIRECT_STATS_EN
         n_checks++;
         if (pred_count !== m_pred_n || mispred_count !== m_mis_n) begin
            n_fail++; $display("FAIL rnd_stats c=%0d got=%0d/%0d exp=%0d/%0d", c, pred_count, mispred_count, m_pred_n, m_mis_n);
         end
`endif
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_predict();
      test_mispredict();
      test_full();
      test_priority();
      test_underflow();
      test_recover_jump();
      test_reset_mid_recover();
      test_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, PC/target width.
REQ-002 SHALL have parameter DEPTH, default 4, pending-branch queue entries (power of 2, >=2).
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2, recovery length in cycles (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port pred_valid  input  1  fetch-stage predictor marks a predicted-taken branch this cycle.
REQ-007 SHALL have port pred_pc  input  DATA_WIDTH  PC of the predicted branch.
REQ-008 SHALL have port pred_target  input  DATA_WIDTH  predicted-taken target.
REQ-009 SHALL have port resolve_valid  input  1  execute stage resolves the oldest pending branch.
REQ-010 SHALL have port resolve_taken  input  1  actual branch outcome.
REQ-011 SHALL have port jump_valid  input  1  execute-stage unconditional jump.
REQ-012 SHALL have port jump_target  input  DATA_WIDTH  jump destination.
REQ-013 SHALL have port redirect_valid  output  1  fetch PC override strobe.
REQ-014 SHALL have port redirect_pc  output  DATA_WIDTH  override PC.
REQ-015 SHALL have port flush  output  1  kill younger pipeline instructions.
REQ-016 SHALL have port stall_fetch  output  1  queue full, fetch must hold.
REQ-017 SHALL have port err_underflow  output  1  sticky: resolve seen with empty queue.

Function
REQ-018 SHALL keep a FIFO of DEPTH entries holding fallthrough address pred_pc+4 (modulo 2^DATA_WIDTH), plus count 0..DEPTH.
REQ-019 SHALL, in IDLE with pred_valid and count<DEPTH, push pred_pc+4 and drive redirect_valid=1, redirect_pc=pred_target next cycle (1-cycle registered latency).
REQ-020 SHALL drive stall_fetch combinationally = (count==DEPTH); pred_valid while full is ignored (no push, no redirect).
REQ-021 SHALL, on resolve_valid with count>0, pop head; resolve_taken=1 -> no redirect, no flush.
REQ-022 SHALL, on resolve_valid, resolve_taken=0, count>0: next cycle redirect_valid=1, redirect_pc=popped fallthrough; clear queue; enter RECOVER.
REQ-023 SHALL, on jump_valid: next cycle redirect_valid=1, redirect_pc=jump_target; clear queue; enter RECOVER.
REQ-024 SHALL prioritise jump_valid > mispredict > pred_valid in one cycle; a lower-priority pred_valid is dropped.
REQ-025 SHALL allow push and correct-pop in the same IDLE cycle: count unchanged, FIFO order preserved.
REQ-026 SHALL, in RECOVER, hold flush=1 for exactly FLUSH_CYCLES cycles starting the cycle redirect_valid asserts, ignore pred_valid and resolve_valid, then return to IDLE.
REQ-027 SHALL accept jump_valid in RECOVER: re-redirect and restart the FLUSH_CYCLES count.
REQ-028 SHALL, on resolve_valid with count==0, set err_underflow=1 until reset and take no other action.
REQ-029 SHALL hold redirect_valid high for exactly one cycle per redirect event.

Reset
REQ-030 SHALL on rst_n=0 immediately clear: state=IDLE, count=0, pointers=0, redirect_valid=0, redirect_pc=0, flush=0, err_underflow=0, stall_fetch=0, statistics counters=0.
REQ-031 SHALL abandon any recovery on reset mid-RECOVER; first edge after release behaves as IDLE.

Configuration
REQ-032 SHALL compile, when PC_REDIRECT_STATS_EN is defined, outputs pred_count and mispred_count (32 bits each, wrapping) incrementing per accepted push and per REQ-022 event.
REQ-033 SHALL, without PC_REDIRECT_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-034 SHALL test: pred_valid, pred_pc=0x100, pred_target=0x140 -> next cycle redirect_valid=1, redirect_pc=0x140, count=1.
REQ-035 SHALL test: after REQ-034, resolve_valid, resolve_taken=0 -> redirect_pc=0x104, flush high 2 cycles, count=0.
REQ-036 SHALL test: 4 pushes without resolve -> stall_fetch=1; 5th pred_valid gives no redirect; one taken resolve -> stall_fetch=0.
REQ-037 SHALL test: jump_valid target 0x200 with mispredict and pred_valid same cycle -> redirect_pc=0x200 only, queue cleared.
REQ-038 SHALL test: resolve_valid at count=0 -> err_underflow=1, no redirect; rst_n low mid-RECOVER -> all outputs 0 asynchronously.
